// File: rtl/fp_norm_scheduler.sv
// rtl/fp_norm_scheduler.sv - round-robin shared leading-zero normalizer for FP32 mantissa products
// Two-stage pipeline: S1 holds the accepted operand, S2 is the registered normalized result.
module fp_norm_scheduler #(
  parameter int NREQ = 4,
  parameter int EW   = 10,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*48-1:0]   req_mant,
  input  logic [NREQ*EW-1:0]   req_exp,
  input  logic [NREQ-1:0]      req_sign,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [47:0]          resp_mant,
  output logic [EW-1:0]        resp_exp,
  output logic                 resp_sign,
  output logic                 resp_zero,
  output logic                 resp_uflow
);

  logic [IDW-1:0] rr;
  logic [IDW-1:0] grant;
  logic           grant_found;
  int             idx;

  logic           s1_v;
  logic [47:0]    s1_mant;
  logic [EW-1:0]  s1_exp;
  logic           s1_sign;
  logic [IDW-1:0] s1_id;

  logic           s2_take;
  logic           s1_free;
  logic           accept;

  logic [5:0]     lz;
  logic           lz_found;
  logic           s1_zero;
  logic [47:0]    norm_mant;
  logic [EW-1:0]  exp_adj;

  // Search starts at rr and wraps, so the most recently served requester is checked last.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant       = IDW'(idx);
        grant_found = 1'b1;
      end
    end
  end

  assign s2_take = s1_v & (~resp_valid | resp_ready);
  assign s1_free = ~s1_v | ~resp_valid | resp_ready;
  assign accept  = rst_n & grant_found & s1_free;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    lz       = 6'd0;
    lz_found = 1'b0;
    for (int i = 47; i >= 0; i--) begin
      if (!lz_found && s1_mant[i]) begin
        lz       = 6'(47 - i);
        lz_found = 1'b1;
      end
    end
  end

  assign s1_zero   = (s1_mant == 48'd0);
  assign norm_mant = s1_mant << lz;
  assign exp_adj   = s1_exp + EW'(1) - EW'(lz);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr      <= '0;
      s1_v    <= 1'b0;
      s1_mant <= '0;
      s1_exp  <= '0;
      s1_sign <= 1'b0;
      s1_id   <= '0;
    end else begin
      if (accept) begin
        s1_v    <= 1'b1;
        s1_mant <= req_mant[grant*48 +: 48];
        s1_exp  <= req_exp[grant*EW +: EW];
        s1_sign <= req_sign[grant];
        s1_id   <= grant;
        rr      <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
      end else if (s2_take) begin
        s1_v <= 1'b0;
      end
    end
  end

  // Result registers only change on a load or a drain, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_mant  <= '0;
      resp_exp   <= '0;
      resp_sign  <= 1'b0;
      resp_zero  <= 1'b0;
      resp_uflow <= 1'b0;
    end else if (s2_take) begin
      resp_valid <= 1'b1;
      resp_id    <= s1_id;
      resp_sign  <= s1_sign;
      resp_zero  <= s1_zero;
      if (s1_zero) begin
        resp_mant  <= '0;
        resp_exp   <= '0;
        resp_uflow <= 1'b0;
      end else begin
        resp_mant  <= norm_mant;
        resp_exp   <= exp_adj;
        resp_uflow <= exp_adj[EW-1] | (exp_adj == '0);
      end
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fp_norm_scheduler.sv
// tb/tb_fp_norm_scheduler.sv - self-checking bench for fp_norm_scheduler
module tb_fp_norm_scheduler;
  localparam int NREQ = 4;
  localparam int EW   = 10;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, req_sign;
  logic [NREQ*48-1:0]   req_mant;
  logic [NREQ*EW-1:0]   req_exp;
  logic                 resp_valid, resp_ready;
  logic [IDW-1:0]       resp_id;
  logic [47:0]          resp_mant;
  logic [EW-1:0]        resp_exp;
  logic                 resp_sign, resp_zero, resp_uflow;

  fp_norm_scheduler #(.NREQ(NREQ), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mant(req_mant),
    .req_exp(req_exp), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_mant(resp_mant), .resp_exp(resp_exp), .resp_sign(resp_sign),
    .resp_zero(resp_zero), .resp_uflow(resp_uflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [47:0] mant;
    logic [EW-1:0] exp;
    logic        sign;
    logic        zero;
    logic        uflow;
    int          t;
  } item_t;

  item_t q[$];
  int    acc_log[$];
  int    errors = 0, checks = 0;
  int    now = 0, m_rr = 0, n_resp = 0, n_acc = 0;
  int    last_id;
  logic [47:0]   last_mant;
  logic [EW-1:0] last_exp;
  logic          last_zero, last_uflow;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Normalize by shifting until the top bit is set, counting the shifts.
  function automatic item_t model(int id, logic [47:0] m, logic [EW-1:0] e, logic s, int t);
    item_t r;
    logic [47:0] x;
    int lz, ev;
    r.id = id; r.sign = s; r.t = t; r.zero = (m == 48'd0);
    x = m; lz = 0;
    if (r.zero) begin
      r.mant = '0; r.exp = '0; r.uflow = 1'b0;
    end else begin
      while (x[47] == 1'b0) begin x = x << 1; lz++; end
      ev = $signed(e) + 1 - lz;
      r.mant = x;
      r.exp = EW'(ev);
      r.uflow = ($signed(r.exp) <= 0);
    end
    return r;
  endfunction

  task automatic rand_data();
    logic [63:0] r;
    for (int i = 0; i < NREQ; i++) begin
      r = {$urandom, $urandom};
      r = r >> $urandom_range(16, 64);
      req_mant[48*i +: 48] = r[47:0];
      req_exp[EW*i +: EW]  = EW'($urandom);
      req_sign[i]          = 1'($urandom);
    end
  endtask

  task automatic tick();
    int g, j;
    logic [NREQ-1:0] want_ready;
    item_t h;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NREQ; k++) begin
      j = (m_rr + k) % NREQ;
      if (g < 0 && req_valid[j]) g = j;
    end
    want_ready = '0;
    if (g >= 0 && (q.size() < 2 || resp_ready)) want_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(want_ready));
    chk("resp_valid", 64'(resp_valid), 64'(q.size() > 0 && q[0].t <= now - 2));
    if (resp_valid && q.size() > 0) begin
      h = q[0];
      chk("resp_id", 64'(resp_id), 64'(h.id));
      chk("resp_mant", 64'(resp_mant), 64'(h.mant));
      chk("resp_exp", 64'(resp_exp), 64'(h.exp));
      chk("resp_sign", 64'(resp_sign), 64'(h.sign));
      chk("resp_zero", 64'(resp_zero), 64'(h.zero));
      chk("resp_uflow", 64'(resp_uflow), 64'(h.uflow));
      if (resp_ready) begin
        void'(q.pop_front());
        last_id = int'(resp_id); last_mant = resp_mant; last_exp = resp_exp;
        last_zero = resp_zero; last_uflow = resp_uflow;
        n_resp++;
      end
    end
    if (g >= 0 && req_ready[g]) begin
      q.push_back(model(g, req_mant[48*g +: 48], req_exp[EW*g +: EW], req_sign[g], now));
      acc_log.push_back(g);
      m_rr = (g + 1) % NREQ;
      n_acc++;
    end
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic send(input int i, input logic [47:0] m, input logic [EW-1:0] e);
    int cnt, a0, r0;
    cnt = 0; a0 = n_acc; r0 = n_resp;
    req_valid = '0; req_valid[i] = 1'b1;
    req_mant[48*i +: 48] = m; req_exp[EW*i +: EW] = e; req_sign[i] = 1'b1;
    resp_ready = 1'b1;
    while (n_acc == a0 && cnt < 20) begin tick(); cnt++; end
    req_valid = '0;
    while (n_resp == r0 && cnt < 40) begin tick(); cnt++; end
    chk("send_done", 64'(n_resp), 64'(r0 + 1));
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    req_valid = '0; resp_ready = 1'b1;
    while (q.size() > 0 && cnt < 20) begin tick(); cnt++; end
    tick();
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  initial begin
    int a0, r0;
    logic [47:0] s_mant;
    logic [IDW-1:0] s_id;
    logic [EW-1:0] s_exp;
    rst_n = 1'b1;
    req_valid = '1; req_mant = '0; req_exp = '0; req_sign = '0; resp_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_mant", 64'(resp_mant), 64'd0);
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    send(2, 48'h0000_0100_0000, EW'(127));
    chk("d1_id", 64'(last_id), 64'd2);
    chk("d1_mant", 64'(last_mant), 64'h8000_0000_0000);
    chk("d1_exp", 64'(last_exp), 64'd105);
    send(1, 48'h0, EW'(50));
    chk("zero_flag", 64'(last_zero), 64'd1);
    chk("zero_mant", 64'(last_mant), 64'd0);
    chk("zero_exp", 64'(last_exp), 64'd0);
    chk("zero_uflow", 64'(last_uflow), 64'd0);
    send(0, 48'h8000_0000_0000, EW'(127));
    chk("lz0_exp", 64'(last_exp), 64'd128);
    send(3, 48'h1, EW'(127));
    chk("lz47_exp", 64'(last_exp), 64'd81);
    send(2, 48'h1, EW'(20));
    chk("uflow_exp", 64'(last_exp), 64'h3E6);
    chk("uflow_flag", 64'(last_uflow), 64'd1);
    drain();

    // Backpressure with all requesters valid and an empty pipe.
    req_valid = '1; resp_ready = 1'b0; rand_data();
    a0 = n_acc;
    repeat (3) tick();
    s_mant = resp_mant; s_id = resp_id; s_exp = resp_exp;
    repeat (2) tick();
    chk("bp_accepts", 64'(n_acc - a0), 64'd2);
    chk("bp_ready_zero", 64'(req_ready), 64'd0);
    chk("bp_stable_mant", 64'(resp_mant), 64'(s_mant));
    chk("bp_stable_id", 64'(resp_id), 64'(s_id));
    chk("bp_stable_exp", 64'(resp_exp), 64'(s_exp));
    r0 = n_resp;
    drain();
    chk("bp_drained", 64'(n_resp - r0), 64'd2);

    // Async reset in the middle of a stream.
    req_valid = '1; resp_ready = 1'b1;
    repeat (3) begin rand_data(); tick(); end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid), 64'd0);
    chk("arst_req_ready", 64'(req_ready), 64'd0);
    chk("arst_resp_id", 64'(resp_id), 64'd0);
    chk("arst_resp_exp", 64'(resp_exp), 64'd0);
    q.delete(); m_rr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fairness: all valid then requester 1 dropped.
    acc_log.delete();
    repeat (12) begin rand_data(); tick(); end
    chk("fair_count", 64'(acc_log.size()), 64'd12);
    for (int k = 0; k < 12 && k < acc_log.size(); k++)
      chk("fair_order", 64'(acc_log[k]), 64'(k % NREQ));
    req_valid = 4'b1101;
    acc_log.delete();
    repeat (6) begin rand_data(); tick(); end
    chk("skip_count", 64'(acc_log.size()), 64'd6);
    for (int k = 0; k < acc_log.size(); k++)
      chk("skip_1", 64'(acc_log[k] != 1), 64'd1);
    drain();

    // Random traffic against the reference model.
    repeat (300) begin
      req_valid = NREQ'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rand_data();
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fp_norm_scheduler.md
# fp_norm_scheduler

Round-robin scheduler that shares one 48-bit leading-zero-detect/normalize datapath among `NREQ` processing elements of the systolic FP32 multiplier array. Each PE hands over an unnormalized 48-bit mantissa product with its exponent and sign. The block arbitrates, runs leading-zero detection and a left shift in a two-stage stall-able pipeline, and returns a normalized result tagged with the requester ID. It sits between the PE multiply stage and the shared rounding/pack stage.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `EW`, 10: signed two's-complement exponent width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester valid.
- `req_ready`  out  NREQ  per-requester ready; one-hot or zero.
- `req_mant`  in  NREQ*48  mantissa product, requester i at [48i+47:48i]; binary point between bits 46 and 45.
- `req_exp`  in  NREQ*EW  signed biased exponent, requester i at [EW*i+EW-1:EW*i].
- `req_sign`  in  NREQ  sign bits.
- `resp_valid`  out  1  result valid.
- `resp_ready`  in  1  downstream accept.
- `resp_id`  out  $clog2(NREQ)  index of the originating requester.
- `resp_mant`  out  48  normalized mantissa; bit 47 = 1 unless zero.
- `resp_exp`  out  EW  adjusted exponent.
- `resp_sign`  out  1  passed-through sign.
- `resp_zero`  out  1  input mantissa was zero.
- `resp_uflow`  out  1  adjusted exponent ≤ 0 (signed).

## Operation
- **Arbitration:** round-robin pointer `rr` (reset 0). Search starts at index `rr`, wraps modulo NREQ, and grants the first requester with `req_valid`=1.
- `req_ready[g]` = `s1_free` for granted g only. All other bits are 0. `req_ready` may depend combinationally on `req_valid`; `req_valid` must not depend on `req_ready`.
- **Accept:** occurs when `req_valid[g] & req_ready[g]`. On accept, `rr` ← (g+1) mod NREQ. With no accept, `rr` holds.
- **Fairness:** a continuously asserted requester is accepted within NREQ accepts.
- **Stage 1 (S1):** registers mant, exp, sign, and id.
  - `s1_free` = ~S1.v | (S2 free to load).
- **Stage 2 (S2) / output:** computes and registers the result.
  - lz = leading-zero count of S1 mant (0..47).
  - `resp_mant` = mant << lz.
  - `resp_exp` = exp + 1 − lz, in EW-bit signed arithmetic, wrap on overflow.
  - `resp_zero` = (mant==0). When zero: `resp_mant`=0, `resp_exp`=0, `resp_uflow`=0.
  - `resp_uflow` = ~zero & (`resp_exp` ≤ 0).
- **Pipeline advance:**
  - S2 loads from S1 when S1.v & (~`resp_valid` | `resp_ready`).
  - `resp_valid` clears on `resp_ready` when S1 has nothing to load.
  - S1 loads on accept. If no accept but S2 takes S1, S1.v clears.
- **Output stability:** while `resp_valid`=1 and `resp_ready`=0, all `resp_*` outputs stay stable. S1 holds, and no new accept happens if S1 is occupied.

## Timing
- **Reset:** all outputs 0, `req_ready`=0 during reset. After reset, S1.v=0, S2.v=0, `rr`=0.
- **Reset mid-operation:** discards in-flight items. Nothing is replayed.
- **Latency:** accept at edge N means `resp_valid`=1 after edge N+1 (2-register path, one result visible per cycle).
- **Throughput:** 1 accept/cycle with `resp_ready` held at 1.
- **Full pipe:** with S1 and S2 both valid and `resp_ready`=0, `req_ready` is all zero.
- **Simultaneous events:**
  - `resp_ready` and a new accept in the same cycle: S2←S1 and S1←new both occur. No bubble, no loss.
  - All NREQ valid together: granted in order rr, rr+1, … with wrap.

## Test plan
- **Single request, requester 2:** mant=48'h0000_0100_0000, exp=127, `resp_ready`=1 → two cycles later `resp_valid`=1, `resp_id`=2, lz=23, `resp_mant`=48'h8000_0000_0000, `resp_exp`=105.
- **Zero mantissa and boundary counts:**
  - mant=0, exp=50 → `resp_zero`=1, `resp_mant`=0, `resp_exp`=0, `resp_uflow`=0.
  - mant=48'h8000_0000_0000, exp=127 → `resp_exp`=128.
  - mant=48'h1, exp=127 → `resp_exp`=81.
- **Underflow:** mant=48'h0000_0000_0001, exp=20 → `resp_exp`=−26 (EW-bit two's complement), `resp_uflow`=1.
- **Fairness, NREQ=4, all valid for 12 cycles, `resp_ready`=1:** `resp_id` sequence is 0,1,2,3,0,1,2,3,0,1,2,3. Then drop `req_valid[1]` → sequence skips 1.
- **Backpressure:** `resp_ready`=0 for 5 cycles with all requesters valid.
  - Exactly 2 accepts occur, `req_ready` is then 0, and `resp_*` stays stable.
  - On release, results drain in accept order with no loss or duplication.
- **Async reset:** assert `rst_n`=0 mid-stream between clock edges → outputs 0 immediately. After release, the first grant goes to requester 0.
